// File: rtl/xor_multiport_ram_pkg.sv
// Shared types and elaboration helpers for the XOR-encoded multi-port RAM.
package xor_multiport_ram_pkg;

  // Controller states: zero-fill sweep after reset, then normal service.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Address width for a given depth.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Copies held by each write-port row: one per read port plus one per
  // other write port.
  function automatic int copies_per_row(input int rports, input int wports);
    return rports + wports - 1;
  endfunction

  // Slot inside row `row` that serves write port `wp` (wp != row).
  // Read-port copies occupy slots 0..rports-1; write-port copies follow,
  // skipping the row's own port.
  function automatic int wcopy_idx(input int wp, input int row, input int rports);
    return rports + ((wp < row) ? wp : wp - 1);
  endfunction

endpackage

// File: rtl/xor_bank_copy.sv
// One bank copy: single write port, single read port, registered read-first
// output. The output register clears on reset so idle read ports read zero.
module xor_bank_copy #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array write.
  // NOTE: the array itself is never reset; the controller's zero-fill sweep
  // clears it, which keeps this a plain RAM macro rather than a flop bank.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; sampling mem before the same-edge write gives read-first.
  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/xor_multiport_ram.sv
// XOR-encoded multi-port RAM: WPORTS write ports and RPORTS read ports, all
// serviced every cycle once the post-reset zero-fill completes.
// Optional build macro XOR_MULTIPORT_RAM_BYPASS_EN: reads sampled on a write's
// commit edge return the committing data instead of the old word.
module xor_multiport_ram
  import xor_multiport_ram_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int WPORTS = 2,
  parameter int RPORTS = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  ready,
  input  logic [WPORTS-1:0]                     wr_en,
  input  logic [WPORTS-1:0][$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [WPORTS-1:0][WIDTH-1:0]          wr_data,
  output logic                                  wr_collision,
  input  logic [RPORTS-1:0]                     rd_en,
  input  logic [RPORTS-1:0][$clog2(DEPTH)-1:0]  rd_addr,
  output logic [RPORTS-1:0][WIDTH-1:0]          rd_data,
  output logic [RPORTS-1:0]                     rd_valid
);

  localparam int AW     = addr_w(DEPTH);
  localparam int COPIES = copies_per_row(RPORTS, WPORTS);

  state_t                         state;
  logic [AW-1:0]                  init_cnt;
  logic [WPORTS-1:0]              wr_win;
  logic                           collide;
  logic [WPORTS-1:0]              s_valid;
  logic [WPORTS-1:0][AW-1:0]      s_addr;
  logic [WPORTS-1:0][WIDTH-1:0]   s_data;
  logic [WPORTS-1:0][WPORTS-1:0]  fix_sel;
  logic [WIDTH-1:0]               fix_val [WPORTS][WPORTS];
  logic [WPORTS-1:0][WIDTH-1:0]   commit_val;
  logic [WPORTS-1:0]              row_we;
  logic [WPORTS-1:0][AW-1:0]      row_waddr;
  logic [WPORTS-1:0][WIDTH-1:0]   row_wdata;
  logic [WIDTH-1:0]               bank_q [WPORTS][COPIES];
  logic [RPORTS-1:0][WIDTH-1:0]   rd_xor;

  assign ready = (state == ST_RUN);

  // Zero-fill sweep: one address per cycle, RUN after DEPTH-1 is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == AW'(DEPTH - 1)) state <= ST_RUN;
      init_cnt <= init_cnt + 1'b1;
    end
  end

  // Same-address arbitration: a write loses to any higher-indexed one.
  // NOTE: every output gets a default at the top so no path infers a latch.
  always_comb begin
    wr_win  = '0;
    collide = 1'b0;
    for (int i = 0; i < WPORTS; i++) begin
      wr_win[i] = ready && wr_en[i];
      for (int j = i + 1; j < WPORTS; j++) begin
        if (wr_en[i] && wr_en[j] && (wr_addr[i] == wr_addr[j])) begin
          wr_win[i] = 1'b0;
          collide   = ready;
        end
      end
    end
  end

  // Stage S capture, collision flag and hazard select for the other rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid      <= '0;
      s_addr       <= '0;
      s_data       <= '0;
      fix_sel      <= '0;
      wr_collision <= 1'b0;
    end else begin
      s_valid      <= wr_win;
      s_addr       <= wr_addr;
      s_data       <= wr_data;
      wr_collision <= collide;
      for (int w = 0; w < WPORTS; w++)
        for (int v = 0; v < WPORTS; v++)
          fix_sel[w][v] <= (w != v) && s_valid[v] && (s_addr[v] == wr_addr[w]);
    end
  end

  // Row value being committed now, kept for a same-address write sampled now.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WPORTS; w++)
      for (int v = 0; v < WPORTS; v++)
        fix_val[w][v] <= commit_val[v];
  end

  // Encoded word for each committing port: data XOR every other row's word.
  always_comb begin
    for (int v = 0; v < WPORTS; v++) begin
      commit_val[v] = s_data[v];
      for (int w = 0; w < WPORTS; w++) begin
        if (w != v)
          commit_val[v] ^= fix_sel[v][w] ? fix_val[v][w]
                                         : bank_q[w][wcopy_idx(v, w, RPORTS)];
      end
    end
  end

  // Row write steering: zero-fill during INIT, stage-S commit during RUN.
  always_comb begin
    for (int w = 0; w < WPORTS; w++) begin
      row_we[w]    = !rst && ((state == ST_INIT) || s_valid[w]);
      row_waddr[w] = (state == ST_INIT) ? init_cnt : s_addr[w];
      row_wdata[w] = (state == ST_INIT) ? '0 : commit_val[w];
    end
  end

  for (genvar w = 0; w < WPORTS; w++) begin : g_row
    for (genvar c = 0; c < COPIES; c++) begin : g_copy
      logic          re;
      logic [AW-1:0] ra;
      if (c < RPORTS) begin : g_rd
        assign re = ready && rd_en[c];
        assign ra = rd_addr[c];
      end else begin : g_wr
        localparam int K = c - RPORTS;
        localparam int U = (K < w) ? K : K + 1;
        assign re = wr_win[U];
        assign ra = wr_addr[U];
      end
      xor_bank_copy #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_copy (
        .clk   (clk),
        .rst   (rst),
        .we    (row_we[w]),
        .waddr (row_waddr[w]),
        .wdata (row_wdata[w]),
        .re    (re),
        .raddr (ra),
        .rdata (bank_q[w][c])
      );
    end
  end

  // Decode: a read port's word is the XOR of its copy in every row.
  always_comb begin
    for (int r = 0; r < RPORTS; r++) begin
      rd_xor[r] = '0;
      for (int w = 0; w < WPORTS; w++) rd_xor[r] ^= bank_q[w][r];
    end
  end

  // One-cycle read valid per port.
  always_ff @(posedge clk) begin
    if (rst) rd_valid <= '0;
    else     rd_valid <= ready ? rd_en : '0;
  end

`ifdef XOR_MULTIPORT_RAM_BYPASS_EN
  logic [RPORTS-1:0]            byp_hit;
  logic [RPORTS-1:0][WIDTH-1:0] byp_data;

  // Capture a committing write's data for reads that hit its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit  <= '0;
      byp_data <= '0;
    end else begin
      for (int r = 0; r < RPORTS; r++) begin
        if (ready && rd_en[r]) begin
          byp_hit[r] <= 1'b0;
          for (int v = 0; v < WPORTS; v++) begin
            if (s_valid[v] && (s_addr[v] == rd_addr[r])) begin
              byp_hit[r]  <= 1'b1;
              byp_data[r] <= s_data[v];
            end
          end
        end
      end
    end
  end

  for (genvar r = 0; r < RPORTS; r++) begin : g_byp
    assign rd_data[r] = byp_hit[r] ? byp_data[r] : rd_xor[r];
  end
`else
  assign rd_data = rd_xor;
`endif

endmodule

// File: tb/tb_xor_multiport_ram.sv
// Self-checking bench for xor_multiport_ram (WIDTH=8, DEPTH=16, 2W/2R).
// Reference: a plain word array plus last cycle's sampled writes, applied in
// port order so the highest-indexed port wins.
module tb_xor_multiport_ram;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int WPORTS = 2;
  localparam int RPORTS = 2;
  localparam int AW     = 4;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic                            ready;
  logic [WPORTS-1:0]               wr_en   = '0;
  logic [WPORTS-1:0][AW-1:0]       wr_addr = '0;
  logic [WPORTS-1:0][WIDTH-1:0]    wr_data = '0;
  logic                            wr_collision;
  logic [RPORTS-1:0]               rd_en   = '0;
  logic [RPORTS-1:0][AW-1:0]       rd_addr = '0;
  logic [RPORTS-1:0][WIDTH-1:0]    rd_data;
  logic [RPORTS-1:0]               rd_valid;

  always #5 clk = ~clk;

  xor_multiport_ram #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .WPORTS(WPORTS), .RPORTS(RPORTS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_collision (wr_collision),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid)
  );

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] mem    [DEPTH];
  logic [WIDTH-1:0] exp_rd [RPORTS];
  logic             pend_v [WPORTS];
  logic [AW-1:0]    pend_a [WPORTS];
  logic [WIDTH-1:0] pend_d [WPORTS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    for (int w = 0; w < WPORTS; w++) pend_v[w] = 1'b0;
    for (int r = 0; r < RPORTS; r++) exp_rd[r] = '0;
  endtask

  // Release reset and count cycles until ready, throwing junk requests that
  // must be ignored while the sweep runs.
  task automatic wait_init(input string tag);
    int cnt = 0;
    rst = 1'b0;
    while (!ready && cnt < 4 * DEPTH) begin
      wr_en   = 2'b11;
      wr_addr = {2{AW'($urandom_range(0, DEPTH - 1))}};
      wr_data = WPORTS * WIDTH'($urandom);
      rd_en   = RPORTS'($urandom);
      rd_addr = RPORTS * AW'($urandom);
      @(posedge clk); #1;
      cnt++;
      check({tag, "_rd_valid_low"}, 32'(rd_valid), 32'd0);
      check({tag, "_collision_low"}, 32'(wr_collision), 32'd0);
    end
    check({tag, "_init_len"}, cnt, DEPTH);
    idle();
  endtask

  // One RUN cycle: predict from the model, clock, compare.
  task automatic step();
    logic [RPORTS-1:0] exp_vld;
    logic              exp_col;
    for (int r = 0; r < RPORTS; r++) begin
      exp_vld[r] = rd_en[r];
      if (rd_en[r]) begin
        exp_rd[r] = mem[rd_addr[r]];
`ifdef XOR_MULTIPORT_RAM_BYPASS_EN
        for (int w = 0; w < WPORTS; w++)
          if (pend_v[w] && pend_a[w] == rd_addr[r]) exp_rd[r] = pend_d[w];
`endif
      end
    end
    for (int w = 0; w < WPORTS; w++)
      if (pend_v[w]) mem[pend_a[w]] = pend_d[w];
    exp_col = 1'b0;
    for (int w = 0; w < WPORTS; w++)
      for (int u = w + 1; u < WPORTS; u++)
        if (wr_en[w] && wr_en[u] && wr_addr[w] == wr_addr[u]) exp_col = 1'b1;
    for (int w = 0; w < WPORTS; w++) begin
      pend_v[w] = wr_en[w];
      pend_a[w] = wr_addr[w];
      pend_d[w] = wr_data[w];
    end
    @(posedge clk); #1;
    check("ready", 32'(ready), 32'd1);
    check("rd_valid", 32'(rd_valid), 32'(exp_vld));
    check("wr_collision", 32'(wr_collision), 32'(exp_col));
    for (int r = 0; r < RPORTS; r++)
      check($sformatf("rd_data%0d", r), 32'(rd_data[r]), 32'(exp_rd[r]));
  endtask

  task automatic write1(input int port, input int addr, input logic [WIDTH-1:0] data);
    wr_en[port]   = 1'b1;
    wr_addr[port] = AW'(addr);
    wr_data[port] = data;
  endtask

  task automatic read1(input int port, input int addr);
    rd_en[port]   = 1'b1;
    rd_addr[port] = AW'(addr);
  endtask

  logic [WIDTH-1:0] byp_exp;

  initial begin
    model_reset();
    idle();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_collision", 32'(wr_collision), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);

    // Reset pulse mid-sweep restarts from address 0.
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midinit_ready", 32'(ready), 32'd0);
    wait_init("init");

    // Every address reads zero on both ports.
    for (int a = 0; a < DEPTH; a++) begin
      read1(0, a);
      read1(1, DEPTH - 1 - a);
      step();
    end
    idle();
    step();
    check("hold_rd_data0", 32'(rd_data[0]), 32'd0);

    // 0x5A@3: same-edge read sees old data, two cycles later sees 0x5A.
    write1(0, 3, 8'h5A);
    read1(1, 3);
    step();
    idle();
    step();
    read1(1, 3);
    step();
    check("wr3_read", 32'(rd_data[1]), 32'h5A);
    idle();

    // Back-to-back writes from different ports to 7: later data survives.
    write1(0, 7, 8'h11);
    step();
    idle();
    write1(1, 7, 8'h22);
    step();
    idle();
    step();
    read1(0, 7);
    step();
    check("b2b_read", 32'(rd_data[0]), 32'h22);
    idle();

    // Same-edge writes to 9: port 1 wins, collision flagged.
    write1(0, 9, 8'hAA);
    write1(1, 9, 8'h55);
    step();
    check("collision_pulse", 32'(wr_collision), 32'd1);
    idle();
    step();
    check("collision_clear", 32'(wr_collision), 32'd0);
    read1(1, 9);
    step();
    check("collision_read", 32'(rd_data[1]), 32'h55);
    idle();

    // Read at the commit edge of 0x3C@2.
    write1(1, 2, 8'h3C);
    step();
    idle();
    read1(0, 2);
    step();
`ifdef XOR_MULTIPORT_RAM_BYPASS_EN
    byp_exp = 8'h3C;
`else
    byp_exp = 8'h00;
`endif
    check("commit_edge_read", 32'(rd_data[0]), 32'(byp_exp));
    idle();

    // Top address is legal.
    write1(0, DEPTH - 1, 8'hE7);
    step();
    idle();
    step();
    read1(0, DEPTH - 1);
    read1(1, DEPTH - 1);
    step();
    check("top_addr", 32'(rd_data[1]), 32'hE7);
    idle();

    // Randomised traffic, often crowded onto a few addresses.
    for (int i = 0; i < 400; i++) begin
      logic narrow;
      narrow = ($urandom_range(0, 1) == 1);
      for (int w = 0; w < WPORTS; w++) begin
        wr_en[w]   = ($urandom_range(0, 2) != 0);
        wr_addr[w] = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
        wr_data[w] = WIDTH'($urandom);
      end
      for (int r = 0; r < RPORTS; r++) begin
        rd_en[r]   = ($urandom_range(0, 2) != 0);
        rd_addr[r] = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      end
      step();
    end
    idle();
    step();
    step();

    // Reset while 0x77@5 is in flight: write discarded, memory re-zeroed.
    write1(0, 5, 8'h77);
    step();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    check("inflight_ready", 32'(ready), 32'd0);
    check("inflight_rd_valid", 32'(rd_valid), 32'd0);
    check("inflight_collision", 32'(wr_collision), 32'd0);
    check("inflight_rd_data", 32'(rd_data), 32'd0);
    model_reset();
    wait_init("reinit");
    read1(0, 5);
    read1(1, 9);
    step();
    check("reinit_read5", 32'(rd_data[0]), 32'd0);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
